// File: rtl/la_capture_core_if.sv
// la_capture_core_if: capture control, trigger configuration and readout
// signals of the logic-analyser capture engine. The capture core is the
// slave; the probe / JTAG-side logic that drives it is the master.
interface la_capture_core_if #(
  parameter int DATA_W = 20,
  parameter int TRIG_W = 20,
  parameter int DEPTH  = 1024
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              en_i;
  logic [DATA_W-1:0] data_i;
  logic [TRIG_W-1:0] trig_i;
  logic [TRIG_W-1:0] trig_mask_i;
  logic [TRIG_W-1:0] trig_value_i;
  logic [1:0]        trig_mode_i;
  logic [ADDR_W-1:0] pretrig_i;
  logic              arm_i;
  logic              abort_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [DATA_W-1:0] rd_data_o;
  logic [2:0]        state_o;
  logic              triggered_o;
  logic              done_o;
  logic [ADDR_W-1:0] trig_addr_o;

  modport master (
    output en_i, data_i, trig_i, trig_mask_i, trig_value_i, trig_mode_i,
           pretrig_i, arm_i, abort_i, rd_addr_i,
    input  rd_data_o, state_o, triggered_o, done_o, trig_addr_o
  );

  modport slave (
    input  en_i, data_i, trig_i, trig_mask_i, trig_value_i, trig_mode_i,
           pretrig_i, arm_i, abort_i, rd_addr_i,
    output rd_data_o, state_o, triggered_o, done_o, trig_addr_o
  );
endinterface

// File: rtl/la_capture_core.sv
// la_capture_core: on-chip logic-analyser capture engine. Samples a bus into
// a circular RAM, keeps a programmable pre-trigger window, evaluates a masked
// trigger in one of four modes, and exposes the finished capture through a
// trigger-relative synchronous read port. DEPTH must be a power of two >= 4.
module la_capture_core #(
  parameter int DATA_W = 20,
  parameter int TRIG_W = 20,
  parameter int DEPTH  = 1024
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  la_capture_core_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] PRE_MAX  = ADDR_W'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  localparam logic [1:0] MODE_LEVEL  = 2'b00;
  localparam logic [1:0] MODE_RISE   = 2'b01;
  localparam logic [1:0] MODE_CHANGE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // At least one sample after the trigger is always kept, so the pre-window
  // saturates two below the depth.
  function automatic logic [ADDR_W-1:0] clamp_pretrig(input logic [ADDR_W-1:0] req);
    return (req > PRE_MAX) ? PRE_MAX : req;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] pretrig_q, pretrig_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [1:0]        mode_q, mode_d;
  logic [TRIG_W-1:0] trig_prev_q, trig_prev_d;
  logic              m_prev_q, m_prev_d;
  logic              triggered_q, triggered_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              trig_match;
  logic              trig_hit;
  logic              capturing;
  logic              wr_en;
  logic [ADDR_W-1:0] pretrig_req;
  logic [ADDR_W-1:0] post_len;
  logic [ADDR_W-1:0] pre_cnt_inc;
  logic [ADDR_W-1:0] post_cnt_inc;
  logic [ADDR_W-1:0] rd_phys;

  assign trig_match   = ((bus.trig_i ^ bus.trig_value_i) & bus.trig_mask_i) == '0;
  assign capturing    = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign wr_en        = bus.en_i && capturing;
  assign pretrig_req  = clamp_pretrig(bus.pretrig_i);
  assign post_len     = LAST_IDX - pretrig_q;
  assign pre_cnt_inc  = pre_cnt_q + 1'b1;
  assign post_cnt_inc = post_cnt_q + 1'b1;
  // Logical index 0 is the oldest retained sample, pretrig the trigger sample.
  assign rd_phys      = trig_addr_q - pretrig_q + bus.rd_addr_i;

  // Trigger condition for the mode latched at arm time.
  always_comb begin
    trig_hit = 1'b0;
    case (mode_q)
      MODE_LEVEL:  trig_hit = trig_match;
      MODE_RISE:   trig_hit = trig_match & ~m_prev_q;
      MODE_CHANGE: trig_hit = |((bus.trig_i ^ trig_prev_q) & bus.trig_mask_i);
      default:     trig_hit = 1'b1;
    endcase
  end

  // Capture sequencing: next state, counters, trigger bookkeeping and flags.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    pretrig_d   = pretrig_q;
    trig_addr_d = trig_addr_q;
    mode_d      = mode_q;
    trig_prev_d = trig_prev_q;
    m_prev_d    = m_prev_q;
    triggered_d = triggered_q;
    done_d      = done_q;

    // Edge/change history runs in every state so it is already valid at arm.
    if (bus.en_i) begin
      trig_prev_d = bus.trig_i;
      m_prev_d    = trig_match;
    end

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (bus.abort_i) begin
      state_d     = S_IDLE;
      triggered_d = 1'b0;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.arm_i) begin
            pretrig_d   = pretrig_req;
            mode_d      = bus.trig_mode_i;
            pre_cnt_d   = '0;
            post_cnt_d  = '0;
            triggered_d = 1'b0;
            done_d      = 1'b0;
            state_d     = (pretrig_req != '0) ? S_PRE : S_WAIT;
          end
        end
        S_PRE: begin
          // Trigger is deliberately ignored until the pre-window is full.
          if (bus.en_i) begin
            pre_cnt_d = pre_cnt_inc;
            if (pre_cnt_inc == pretrig_q) begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.en_i && trig_hit) begin
            trig_addr_d = wr_ptr_q;
            triggered_d = 1'b1;
            if (post_len == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_POST;
            end
          end
        end
        S_POST: begin
          if (bus.en_i) begin
            post_cnt_d = post_cnt_inc;
            if (post_cnt_inc == post_len) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control and pointer registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      pretrig_q   <= '0;
      trig_addr_q <= '0;
      mode_q      <= '0;
      trig_prev_q <= '0;
      m_prev_q    <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      pretrig_q   <= pretrig_d;
      trig_addr_q <= trig_addr_d;
      mode_q      <= mode_d;
      trig_prev_q <= trig_prev_d;
      m_prev_q    <= m_prev_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
    end
  end

  // Capture RAM write port; contents are never cleared.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= bus.data_i;
    end
  end

  // Registered read port, one cycle from rd_addr_i to rd_data_o.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_phys];
    end
  end

  assign bus.rd_data_o   = rd_data_q;
  assign bus.state_o     = state_q;
  assign bus.triggered_o = triggered_q;
  assign bus.done_o      = done_q;
  assign bus.trig_addr_o = trig_addr_q;

endmodule
